host_cmd_rx: RTL and testbench

Host-to-FPGA command parser on the USB receive path. Consumes the byte stream popped from the FT245 read FIFO, frames fixed-length command packets, verifies an XOR checksum, and either writes a 32-bit configuration register or returns a register's value on a response handshake. Sits between the FT245 interface and the blocks it configures, such as the synthesizer, FIR and FFT controls.

---
 rtl/host_cmd_rx.sv | 201 ++++++++++++++++++++
 tb/tb_host_cmd_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/host_cmd_rx.sv
// ============================================================================
// Module      : host_cmd_rx
// Description : Host command parser for the FT245 receive byte stream. Frames
//               7-byte packets (SYNC CMD P3 P2 P1 P0 CSUM), checks the XOR
//               checksum and writes a config register or returns its value.
//               Optional inter-byte timeout: define HOST_CMD_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module host_cmd_rx #(
    parameter int         NUM_REGS       = 8,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 4000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [NUM_REGS*32-1:0] cfg_regs,
    output logic                  cfg_wr,
    output logic [3:0]            cfg_wr_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [3:0]            resp_addr,
    output logic [31:0]           resp_data,
    output logic                  err,
    output logic [7:0]            err_cnt
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_CMD  = 3'd1;
    localparam logic [2:0] c_PAY  = 3'd2;
    localparam logic [2:0] c_CSUM = 3'd3;
    localparam logic [2:0] c_EXEC = 3'd4;
    localparam logic [2:0] c_RESP = 3'd5;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic        r_rx_ready;
    logic        r_is_wr;
    logic [3:0]  r_addr;
    logic [7:0]  r_xor;
    logic [31:0] r_payload;
    logic [1:0]  r_cnt;
    logic        r_csum_ok;
    logic        r_cfg_wr;
    logic [3:0]  r_cfg_wr_addr;
    logic        r_resp_valid;
    logic [3:0]  r_resp_addr;
    logic [31:0] r_resp_data;
    logic        r_err;
    logic [7:0]  r_err_cnt;
    logic [31:0] w_reg_file [16];

    logic w_accept;
    logic w_addr_ok;
    logic w_exec_ok;
    logic w_do_write;
    logic w_rd_ok;
    logic w_exec_err;
    logic w_timeout;

    assign w_accept   = rx_valid && r_rx_ready;
    assign w_addr_ok  = ({1'b0, r_addr} < 5'(NUM_REGS));
    assign w_exec_ok  = r_csum_ok && w_addr_ok;
    assign w_do_write = (r_state == c_EXEC) && w_exec_ok && r_is_wr;
    assign w_rd_ok    = w_exec_ok && !r_is_wr;
    assign w_exec_err = (r_state == c_EXEC) && !w_exec_ok;

`ifdef HOST_CMD_TIMEOUT_EN
    localparam int c_TW = ($clog2(TIMEOUT_CYCLES + 1) > 12) ? $clog2(TIMEOUT_CYCLES + 1) : 12;

    logic [c_TW-1:0] r_idle_cnt;
    logic            w_waiting;

    assign w_waiting = (r_state == c_CMD) || (r_state == c_PAY) || (r_state == c_CSUM);
    // An accepted byte in the expiry cycle takes priority over the timeout.
    assign w_timeout = w_waiting && !w_accept && (r_idle_cnt == c_TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if (!w_waiting || w_accept || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_rx_ready <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            // Registered so rx_ready is clean and low throughout reset.
            r_rx_ready <= (w_next_state == c_IDLE) || (w_next_state == c_CMD) ||
                          (w_next_state == c_PAY)  || (w_next_state == c_CSUM);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: if (w_accept && (rx_data == SYNC_BYTE)) w_next_state = c_CMD;
            c_CMD:  if (w_accept) w_next_state = c_PAY;
            c_PAY:  if (w_accept && (r_cnt == 2'd3)) w_next_state = c_CSUM;
            c_CSUM: if (w_accept) w_next_state = c_EXEC;
            c_EXEC: w_next_state = w_rd_ok ? c_RESP : c_IDLE;
            c_RESP: if (resp_ready) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
        if (w_timeout) w_next_state = c_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_wr       <= 1'b0;
            r_addr        <= '0;
            r_xor         <= '0;
            r_payload     <= '0;
            r_cnt         <= '0;
            r_csum_ok     <= 1'b0;
            r_cfg_wr      <= 1'b0;
            r_cfg_wr_addr <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_addr   <= '0;
            r_resp_data   <= '0;
            r_err         <= 1'b0;
            r_err_cnt     <= '0;
        end else begin
            r_cfg_wr <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                c_CMD: if (w_accept) begin
                    r_is_wr <= rx_data[7];
                    r_addr  <= rx_data[3:0];
                    r_xor   <= rx_data;
                    r_cnt   <= 2'd0;
                end
                c_PAY: if (w_accept) begin
                    r_payload <= {r_payload[23:0], rx_data};
                    r_xor     <= r_xor ^ rx_data;
                    r_cnt     <= r_cnt + 2'd1;
                end
                c_CSUM: if (w_accept) r_csum_ok <= (rx_data == r_xor);
                c_EXEC: begin
                    if (w_do_write) begin
                        r_cfg_wr      <= 1'b1;
                        r_cfg_wr_addr <= r_addr;
                    end else if (w_rd_ok) begin
                        r_resp_valid <= 1'b1;
                        r_resp_addr  <= r_addr;
                        r_resp_data  <= w_reg_file[r_addr];
                    end
                end
                c_RESP: if (resp_ready) r_resp_valid <= 1'b0;
                default: ;
            endcase
            if (w_exec_err || w_timeout) begin
                r_err <= 1'b1;
                if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    // Unimplemented addresses read as zero so the read mux is always 16-wide.
    for (genvar k = 0; k < 16; k++) begin : g_reg
        if (k < NUM_REGS) begin : g_impl
            logic [31:0] r_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_reg <= '0;
                end else if (w_do_write && (r_addr == 4'(k))) begin
                    r_reg <= r_payload;
                end
            end
            assign w_reg_file[k]     = r_reg;
            assign cfg_regs[32*k +: 32] = r_reg;
        end else begin : g_tie
            assign w_reg_file[k] = '0;
        end
    end

    assign rx_ready    = r_rx_ready;
    assign cfg_wr      = r_cfg_wr;
    assign cfg_wr_addr = r_cfg_wr_addr;
    assign resp_valid  = r_resp_valid;
    assign resp_addr   = r_resp_addr;
    assign resp_data   = r_resp_data;
    assign err         = r_err;
    assign err_cnt     = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_host_cmd_rx.sv
// ============================================================================
// Module      : tb_host_cmd_rx
// Description : Directed self-checking bench for host_cmd_rx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_host_cmd_rx;

    localparam int NUM_REGS = 8;

    logic                   clk;
    logic                   rst;
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic                   rx_ready;
    logic [NUM_REGS*32-1:0] cfg_regs;
    logic                   cfg_wr;
    logic [3:0]             cfg_wr_addr;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [3:0]             resp_addr;
    logic [31:0]            resp_data;
    logic                   err;
    logic [7:0]             err_cnt;

    int total = 0;
    int bad   = 0;
    int n_wr  = 0;
    int n_err = 0;

    host_cmd_rx #(.NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .cfg_regs(cfg_regs), .cfg_wr(cfg_wr), .cfg_wr_addr(cfg_wr_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_addr(resp_addr),
        .resp_data(resp_data), .err(err), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cfg_wr) n_wr <= n_wr + 1;
        if (err)    n_err <= n_err + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_of(input int k);
        return cfg_regs[32*k +: 32];
    endfunction

    // Offer one byte and return 1 ns after the edge that consumes it.
    task automatic send_byte(input logic [7:0] b, input bit throttle);
        int n;
        if (throttle) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_val("rx_ready_wait", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] pay,
                              input logic [7:0] csum, input bit throttle);
        send_byte(8'hA5, throttle);
        send_byte(cmd, throttle);
        send_byte(pay[31:24], throttle);
        send_byte(pay[23:16], throttle);
        send_byte(pay[15:8], throttle);
        send_byte(pay[7:0], throttle);
        send_byte(csum, throttle);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wr0, err0;
        rst        = 1'b1;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_rx_ready", 32'(rx_ready), 32'd0);
        check_val("rst_regs", 32'(|cfg_regs), 32'd0);
        check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_val("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Write 0x12345678 to register 1 (checksum 0x89).
        send_frame(8'h81, 32'h12345678, 8'h89, 1'b0);
        step();
        check_val("wr_pulse", 32'(cfg_wr), 32'd1);
        check_val("wr_addr", 32'(cfg_wr_addr), 32'd1);
        check_val("wr_reg1", reg_of(1), 32'h12345678);
        check_val("wr_reg0", reg_of(0), 32'h0);
        check_val("wr_err_cnt", 32'(err_cnt), 32'd0);
        step();
        check_val("wr_pulse_end", 32'(cfg_wr), 32'd0);

        // Read back register 1 with the consumer stalled for 5 cycles.
        send_frame(8'h01, 32'h0, 8'h01, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            check_val("rd_valid", 32'(resp_valid), 32'd1);
            check_val("rd_data", resp_data, 32'h12345678);
            check_val("rd_addr", 32'(resp_addr), 32'd1);
            check_val("rd_rx_ready", 32'(rx_ready), 32'd0);
            step();
        end
        @(negedge clk);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check_val("rd_done_valid", 32'(resp_valid), 32'd0);
        check_val("rd_done_ready", 32'(rx_ready), 32'd1);

        // Bad checksum.
        send_frame(8'h81, 32'h12345678, 8'h00, 1'b0);
        step();
        check_val("csum_err", 32'(err), 32'd1);
        check_val("csum_err_cnt", 32'(err_cnt), 32'd1);
        check_val("csum_reg1", reg_of(1), 32'h12345678);
        check_val("csum_no_wr", 32'(cfg_wr), 32'd0);
        step();
        check_val("csum_err_end", 32'(err), 32'd0);

        // Address 15 is out of range.
        send_frame(8'h8F, 32'h0, 8'h8F, 1'b0);
        step();
        check_val("addr_err", 32'(err), 32'd1);
        check_val("addr_err_cnt", 32'(err_cnt), 32'd2);
        check_val("addr_no_wr", 32'(cfg_wr), 32'd0);

        // Garbage then a throttled write of 0xDEADBEEF to register 3.
        step();
        wr0  = n_wr;
        err0 = n_err;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h13, 1'b1);
        send_frame(8'h83, 32'hDEADBEEF, 8'hA1, 1'b1);
        step();
        check_val("thr_reg3", reg_of(3), 32'hDEADBEEF);
        step();
        check_val("thr_one_wr", 32'(n_wr - wr0), 32'd1);
        check_val("thr_no_err", 32'(n_err - err0), 32'd0);
        check_val("thr_err_cnt", 32'(err_cnt), 32'd2);

        // Stall mid-frame.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h82, 1'b0);
        send_byte(8'h12, 1'b0);
        repeat (4100) @(posedge clk);
        #1;
`ifdef HOST_CMD_TIMEOUT_EN
        check_val("to_err_cnt", 32'(err_cnt), 32'd3);
        check_val("to_rx_ready", 32'(rx_ready), 32'd1);
        send_frame(8'h82, 32'h12345678, 8'h8A, 1'b0);
`else
        check_val("stall_err_cnt", 32'(err_cnt), 32'd2);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0);
        send_byte(8'h78, 1'b0);
        send_byte(8'h8A, 1'b0);
`endif
        step();
        check_val("stall_wr_reg2", reg_of(2), 32'h12345678);
        check_val("stall_wr_addr", 32'(cfg_wr_addr), 32'd2);

        // Reset in the middle of a frame.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h81, 1'b0);
        send_byte(8'h12, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("mrst_rx_ready", 32'(rx_ready), 32'd0);
        check_val("mrst_regs", 32'(|cfg_regs), 32'd0);
        check_val("mrst_err_cnt", 32'(err_cnt), 32'd0);
        check_val("mrst_wr_addr", 32'(cfg_wr_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(8'h84, 32'hCAFEF00D, 8'h84 ^ 8'hCA ^ 8'hFE ^ 8'hF0 ^ 8'h0D, 1'b0);
        step();
        check_val("mrst_wr", 32'(cfg_wr), 32'd1);
        check_val("mrst_reg4", reg_of(4), 32'hCAFEF00D);
        check_val("mrst_reg1", reg_of(1), 32'h0);

        // 256 bad frames saturate the error counter.
        for (int i = 0; i < 256; i++) send_frame(8'h81, 32'h0, 8'h00, 1'b0);
        step();
        check_val("sat_err", 32'(err), 32'd1);
        check_val("sat_err_cnt", 32'(err_cnt), 32'hFF);
        check_val("sat_reg4", reg_of(4), 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
